ac_bank: RTL and testbench

- Parametrised successor to the single accumulator: NUM_ACC accumulators of width N in one bank.
- Each accumulator can be loaded from the bus or the ALU, cleared, incremented, decremented, or shifted over multiple cycles.
- Adds registered zero/carry flags, a busy/done handshake for multi-cycle shifts, and a separate R capture register.
- Sits between the system bus, the ALU and the control unit of the FPGA processor.

---
 rtl/ac_bank.sv | 154 +++++++++++++++
 tb/tb_ac_bank.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_bank.sv
// ac_bank: bank of NUM_ACC N-bit accumulators with flags and multi-cycle shifter.
// Optional macro AC_SAT_EN: saturating increment/decrement.
module ac_bank #(
  parameter int N       = 12,
  parameter int NUM_ACC = 4,
  parameter int SELW    = $clog2(NUM_ACC),
  parameter int SHW     = $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SELW-1:0] acc_sel,
  input  logic [N-1:0]    datain,
  input  logic [N-1:0]    alu_out,
  input  logic            alu_to_ac,
  input  logic            write_en,
  input  logic            clr_en,
  input  logic            inc_en,
  input  logic            dec_en,
  input  logic            shift_start,
  input  logic            shift_dir,
  input  logic            shift_arith,
  input  logic [SHW-1:0]  shift_amt,
  input  logic            r_cap_en,
  output logic [N-1:0]    dataout,
  output logic [N-1:0]    r_out,
  output logic            zero_flag,
  output logic            carry_flag,
  output logic            busy,
  output logic            done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [SELW:0]  NACC = (SELW+1)'(NUM_ACC);
  localparam logic [SHW-1:0] NMAX = SHW'(N);

  state_t          state;
  logic [N-1:0]    acc [NUM_ACC];
  logic [SELW-1:0] sh_sel;
  logic            sh_dir;
  logic            sh_arith;
  logic [SHW-1:0]  sh_cnt;

  logic            sel_ok;
  logic [N-1:0]    cur;
  logic            wr;
  logic [N-1:0]    res;
  logic            cy;
  logic [SHW-1:0]  amt_c;
  logic [N-1:0]    sh_val;
  logic [N-1:0]    sh_next;
  logic            sh_out;

  assign sel_ok  = {1'b0, acc_sel} < NACC;
  assign cur     = sel_ok ? acc[acc_sel] : '0;
  assign dataout = cur;
  assign amt_c   = (shift_amt > NMAX) ? NMAX : shift_amt;

  // Single-cycle op select; first match wins, the rest are dropped.
  always_comb begin
    wr  = 1'b0;
    res = cur;
    cy  = 1'b0;
    if (alu_to_ac) begin
      wr  = 1'b1;
      res = alu_out;
    end else if (write_en) begin
      wr  = 1'b1;
      res = datain;
    end else if (clr_en) begin
      wr  = 1'b1;
      res = '0;
    end else if (inc_en) begin
      wr  = 1'b1;
      cy  = &cur;
`ifdef AC_SAT_EN
      res = (&cur) ? cur : cur + 1'b1;
`else
      res = cur + 1'b1;
`endif
    end else if (dec_en) begin
      wr  = 1'b1;
      cy  = ~|cur;
`ifdef AC_SAT_EN
      res = (~|cur) ? cur : cur - 1'b1;
`else
      res = cur - 1'b1;
`endif
    end
  end

  always_comb begin
    sh_val = acc[sh_sel];
    if (sh_dir) begin
      sh_out  = sh_val[0];
      sh_next = {sh_arith & sh_val[N-1], sh_val[N-1:1]};
    end else begin
      sh_out  = sh_val[N-1];
      sh_next = {sh_val[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      r_out      <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sh_sel     <= '0;
      sh_dir     <= 1'b0;
      sh_arith   <= 1'b0;
      sh_cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (r_cap_en) r_out <= datain;
      unique case (state)
        IDLE: begin
          if (sel_ok && wr) begin
            acc[acc_sel] <= res;
            zero_flag    <= (res == '0);
            carry_flag   <= cy;
          end else if (sel_ok && shift_start) begin
            if (amt_c == '0) begin
              done <= 1'b1;
            end else begin
              sh_sel   <= acc_sel;
              sh_dir   <= shift_dir;
              sh_arith <= shift_arith;
              sh_cnt   <= amt_c;
              busy     <= 1'b1;
              state    <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc[sh_sel] <= sh_next;
          carry_flag  <= sh_out;
          sh_cnt      <= sh_cnt - 1'b1;
          if (sh_cnt == SHW'(1)) begin
            zero_flag <= (sh_next == '0);
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_bank.sv
// tb_ac_bank: scenario tasks with a queue scoreboard for ac_bank.
// Build with +define+AC_SAT_EN to check the saturating variant.
module tb_ac_bank;

  localparam int N    = 12;
  localparam int NACC = 4;
  localparam int SELW = 2;
  localparam int SHW  = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [SELW-1:0] acc_sel;
  logic [N-1:0]    datain;
  logic [N-1:0]    alu_out;
  logic            alu_to_ac;
  logic            write_en;
  logic            clr_en;
  logic            inc_en;
  logic            dec_en;
  logic            shift_start;
  logic            shift_dir;
  logic            shift_arith;
  logic [SHW-1:0]  shift_amt;
  logic            r_cap_en;
  logic [N-1:0]    dataout;
  logic [N-1:0]    r_out;
  logic            zero_flag;
  logic            carry_flag;
  logic            busy;
  logic            done;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {dataout, zero, carry, busy, done}
  logic [N+3:0] sb [$];
  logic [N+3:0] exp_v;
  logic [N+3:0] got_v;

  always #5 clk = ~clk;

  ac_bank #(.N(N), .NUM_ACC(NACC)) dut (
    .clk(clk), .rst_n(rst_n), .acc_sel(acc_sel), .datain(datain),
    .alu_out(alu_out), .alu_to_ac(alu_to_ac), .write_en(write_en),
    .clr_en(clr_en), .inc_en(inc_en), .dec_en(dec_en),
    .shift_start(shift_start), .shift_dir(shift_dir),
    .shift_arith(shift_arith), .shift_amt(shift_amt),
    .r_cap_en(r_cap_en), .dataout(dataout), .r_out(r_out),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .busy(busy), .done(done)
  );

  assign got_v = {dataout, zero_flag, carry_flag, busy, done};

  task automatic idle_inputs();
    datain = '0; alu_out = '0; alu_to_ac = 0; write_en = 0;
    clr_en = 0; inc_en = 0; dec_en = 0; shift_start = 0;
    shift_dir = 0; shift_arith = 0; shift_amt = '0; r_cap_en = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [SELW-1:0] s, input logic [N-1:0] v);
    acc_sel = s; datain = v; write_en = 1;
    tick();
    write_en = 0; datain = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    acc_sel = '0;
    rst_n = 0;
    #12;
    rst_n = 1;
    tick();
    for (int i = 0; i < NACC; i++) begin
      acc_sel = SELW'(i);
      sb.push_back({12'h000, 4'b0000});
      #1;
      exp_v = sb.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL reset_acc%0d got=%h want=%h", i, got_v, exp_v);
      end
    end
    n_cmp++;
    if (r_out !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_r_out got=%h want=000", r_out);
    end
  endtask

  task automatic test_inc_wrap();
    load(2'd1, 12'hFFF);
`ifdef AC_SAT_EN
    sb.push_back({12'hFFF, 4'b0100});
`else
    sb.push_back({12'h000, 4'b1100});
`endif
    inc_en = 1;
    tick();
    inc_en = 0;
    exp_v = sb.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL inc_wrap got=%h want=%h", got_v, exp_v);
    end
  endtask

  task automatic test_dec_wrap();
    acc_sel = 2'd2; clr_en = 1;
    sb.push_back({12'h000, 4'b1000});
    tick();
    clr_en = 0;
    exp_v = sb.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL clr got=%h want=%h", got_v, exp_v);
    end
`ifdef AC_SAT_EN
    sb.push_back({12'h000, 4'b1100});
`else
    sb.push_back({12'hFFF, 4'b0100});
`endif
    dec_en = 1;
    tick();
    dec_en = 0;
    exp_v = sb.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL dec_wrap got=%h want=%h", got_v, exp_v);
    end
  endtask

  task automatic test_priority();
    acc_sel = 2'd2; datain = 12'h456; alu_out = 12'h123;
    write_en = 1; clr_en = 1; alu_to_ac = 1; inc_en = 1;
    sb.push_back({12'h123, 4'b0000});
    tick();
    idle_inputs();
    exp_v = sb.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL priority got=%h want=%h", got_v, exp_v);
    end
    acc_sel = 2'd0; datain = 12'h00A; write_en = 1; inc_en = 1;
    sb.push_back({12'h00A, 4'b0000});
    tick();
    idle_inputs();
    exp_v = sb.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL priority_wr_inc got=%h want=%h", got_v, exp_v);
    end
  endtask

  task automatic test_shift_arith();
    int pulses;
    pulses = 0;
    load(2'd0, 12'h801);
    shift_start = 1; shift_dir = 1; shift_arith = 1; shift_amt = 5'd3;
    tick();
    idle_inputs();
    sb.push_back({12'h801, 4'b0010});
    sb.push_back({12'hC00, 4'b0110});
    sb.push_back({12'hE00, 4'b0010});
    sb.push_back({12'hF00, 4'b0001});
    sb.push_back({12'hF00, 4'b0000});
    for (int c = 0; c < 5; c++) begin
      inc_en = (c == 1);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got_v[N+3:3] !== exp_v[N+3:3] || got_v[1:0] !== exp_v[1:0] ||
          (c > 0 && got_v[2] !== exp_v[2])) begin
        n_bad++;
        $display("FAIL shift_arith_c%0d got=%h want=%h", c, got_v, exp_v);
      end
      if (done) pulses++;
      tick();
    end
    inc_en = 0;
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL shift_done_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_shift_zero();
    load(2'd3, 12'h00F);
    shift_start = 1; shift_amt = 5'd0;
    sb.push_back({12'h00F, 4'b0001});
    sb.push_back({12'h00F, 4'b0000});
    tick();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL shift_zero_c%0d got=%h want=%h", c, got_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_shift_clamp();
    int cyc;
    int busy_cyc;
    cyc = 0; busy_cyc = 0;
    load(2'd1, 12'h001);
    shift_start = 1; shift_dir = 0; shift_amt = 5'd20;
    tick();
    idle_inputs();
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      tick();
      cyc++;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL clamp_timeout got=nodone want=done");
    end
    sb.push_back({12'h000, 4'b1101});
    exp_v = sb.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL clamp_result got=%h want=%h", got_v, exp_v);
    end
    n_cmp++;
    if (busy_cyc != 12) begin
      n_bad++;
      $display("FAIL clamp_busy got=%0d want=12", busy_cyc);
    end
  endtask

  task automatic test_rcap_async_reset();
    load(2'd3, 12'h0F0);
    shift_start = 1; shift_amt = 5'd6;
    tick();
    idle_inputs();
    r_cap_en = 1; datain = 12'hABC;
    tick();
    r_cap_en = 0; datain = '0;
    n_cmp++;
    if (r_out !== 12'hABC || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rcap got=%h/%b want=abc/1", r_out, busy);
    end
    #2;
    rst_n = 0;
    #1;
    sb.push_back({12'h000, 4'b0000});
    exp_v = sb.pop_front();
    n_cmp++;
    if (got_v !== exp_v || r_out !== 12'h000) begin
      n_bad++;
      $display("FAIL async_reset got=%h r=%h want=%h r=000", got_v, r_out, exp_v);
    end
    #10;
    rst_n = 1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || dataout !== 12'h000) begin
      n_bad++;
      $display("FAIL post_reset got=%b/%h want=0/000", busy, dataout);
    end
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_dec_wrap();
    test_priority();
    test_shift_arith();
    test_shift_zero();
    test_shift_clamp();
    test_rcap_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
